// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The master issues operations; the slave (the unit) reports status and HI/LO.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic             start;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, with sign fix-up at the end.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  hilo_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
  localparam logic [OPW-1:0] OP_MADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_MSUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(4);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(6);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(7);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_reg;
  logic [OPW-1:0]     op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               dz_reg;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_MADD) ||
                (bus.op == OP_MSUB) || (bus.op == OP_DIV);
    a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: product's upper half accumulates, multiplier shifts out of the low end.
    mul_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, prod_reg[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient}; quotient bits enter at the low end.
    div_shift = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_reg};
    div_ok    = ~div_trial[WIDTH];
    div_next  = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]), prod_reg[WIDTH-2:0], div_ok};

    prod_signed = neg_res_reg ? -prod_reg : prod_reg;
    quo = prod_reg[WIDTH-1:0];
    rem = prod_reg[2*WIDTH-1:WIDTH];

    fix_hi = hi_reg;
    fix_lo = lo_reg;
    case (op_reg)
      OP_MULT, OP_MULTU: {fix_hi, fix_lo} = prod_signed;
      OP_MADD:           {fix_hi, fix_lo} = {hi_reg, lo_reg} + prod_signed;
      OP_MSUB:           {fix_hi, fix_lo} = {hi_reg, lo_reg} - prod_signed;
      OP_DIV, OP_DIVU: begin
        if (opnd_reg == '0) begin
          fix_hi = a_reg;
          fix_lo = '1;
        end else begin
          // Most-negative / -1 wraps to most-negative with zero remainder naturally.
          fix_lo = neg_res_reg ? -quo : quo;
          fix_hi = neg_rem_reg ? -rem : rem;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      opnd_reg    <= '0;
      prod_reg    <= '0;
      cnt_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            op_reg      <= bus.op;
            a_reg       <= bus.a;
            cnt_reg     <= '0;
            neg_res_reg <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_reg <= is_signed & bus.a[WIDTH-1];
            dz_reg      <= 1'b0;
            case (bus.op)
              OP_MTHI: begin
                hi_reg    <= bus.a;
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end
              OP_MTLO: begin
                lo_reg    <= bus.a;
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end
              OP_DIV, OP_DIVU: begin
                opnd_reg  <= b_mag;
                prod_reg  <= {{WIDTH{1'b0}}, a_mag};
                busy_reg  <= 1'b1;
                state_reg <= (bus.b == '0) ? S_FIX : S_DIV;
              end
              default: begin
                opnd_reg  <= a_mag;
                prod_reg  <= {{WIDTH{1'b0}}, b_mag};
                busy_reg  <= 1'b1;
                state_reg <= S_MUL;
              end
            endcase
          end
        end
        S_MUL: begin
          prod_reg <= mul_next;
          if (cnt_reg == CW'(WIDTH - 1)) state_reg <= S_FIX;
          else                           cnt_reg   <= cnt_reg + 1'b1;
        end
        S_DIV: begin
          prod_reg <= div_next;
          if (cnt_reg == CW'(WIDTH - 1)) state_reg <= S_FIX;
          else                           cnt_reg   <= cnt_reg + 1'b1;
        end
        S_FIX: begin
          hi_reg    <= fix_hi;
          lo_reg    <= fix_lo;
          dz_reg    <= ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) && (opnd_reg == '0);
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_DONE;
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.div_zero = dz_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for the HI/LO multiply/divide unit at WIDTH=32 and WIDTH=8,
// with hand-computed results, latencies and handshake behaviour.
module tb_hilo_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_unit_if #(.WIDTH(32), .OPW(3)) bus32 ();
  hilo_muldiv_unit_if #(.WIDTH(8),  .OPW(3)) bus8 ();

  hilo_muldiv_unit #(.WIDTH(32), .OPW(3)) dut (.clk(clk), .rst(rst), .bus(bus32));
  hilo_muldiv_unit #(.WIDTH(8),  .OPW(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op; optionally pulses a stray Start at cycle inj_cyc. Returns Done cycle and busy-cycle count.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int inj_cyc, output int cyc, output int busy_cnt);
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = o; bus32.a = av; bus32.b = bv;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!bus32.done && cyc < 200) begin
      if (bus32.busy) busy_cnt++;
      if (cyc == inj_cyc) begin
        bus32.start = 1'b1; bus32.op = 3'd5; bus32.a = 32'd99; bus32.b = 32'd4;
      end else begin
        bus32.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus32.start = 1'b0;
    chk({tag, "_done_seen"}, {63'd0, bus32.done}, 64'd1);
    $display("op %0d a=%h b=%h -> hi=%h lo=%h dz=%0d done_cycle=%0d busy_cycles=%0d",
             o, av, bv, bus32.hi, bus32.lo, bus32.div_zero, cyc, busy_cnt);
  endtask

  initial begin
    int cyc;
    int bc;
    int done_seen;
    bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0;
    bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi",   {32'd0, bus32.hi}, 64'd0);
    chk("rst_lo",   {32'd0, bus32.lo}, 64'd0);
    chk("rst_busy", {63'd0, bus32.busy}, 64'd0);
    chk("rst_done", {63'd0, bus32.done}, 64'd0);
    chk("rst_dz",   {63'd0, bus32.div_zero}, 64'd0);
    rst = 1'b1;

    do_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, -1, cyc, bc);
    chk("mult_cycle", 64'(cyc), 64'd34);
    chk("mult_busy",  64'(bc), 64'd33);
    chk("mult_hilo",  {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, cyc, bc);
    chk("multu_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("madd", 3'd2, 32'd2, 32'd3, -1, cyc, bc);
    chk("madd_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0007);
    do_op("msub", 3'd3, 32'd1, 32'd8, -1, cyc, bc);
    chk("msub_hilo", {bus32.hi, bus32.lo}, 64'hFFFF_FFFD_FFFF_FFFF);

    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, -1, cyc, bc);
    chk("div_cycle", 64'(cyc), 64'd34);
    chk("div_hilo",  {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu", 3'd5, 32'd7, 32'd2, -1, cyc, bc);
    chk("divu_hilo", {bus32.hi, bus32.lo}, 64'h0000_0001_0000_0003);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, cyc, bc);
    chk("div_ovf_hilo", {bus32.hi, bus32.lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_dz",   {63'd0, bus32.div_zero}, 64'd0);

    do_op("divz", 3'd5, 32'h0000_1234, 32'd0, -1, cyc, bc);
    chk("divz_cycle", 64'(cyc), 64'd2);
    chk("divz_dz",    {63'd0, bus32.div_zero}, 64'd1);
    chk("divz_hilo",  {bus32.hi, bus32.lo}, 64'h0000_1234_FFFF_FFFF);

    do_op("mtlo", 3'd7, 32'h0000_CAFE, 32'd0, -1, cyc, bc);
    chk("mtlo_cycle", 64'(cyc), 64'd1);
    chk("mtlo_busy",  64'(bc) | {63'd0, bus32.busy}, 64'd0);
    chk("mtlo_hilo",  {bus32.hi, bus32.lo}, 64'h0000_1234_0000_CAFE);
    chk("mtlo_dz_cleared", {63'd0, bus32.div_zero}, 64'd0);

    do_op("mthi", 3'd6, 32'h0000_BEEF, 32'd0, -1, cyc, bc);
    chk("mthi_hilo", {bus32.hi, bus32.lo}, 64'h0000_BEEF_0000_CAFE);

    do_op("mult_inj", 3'd0, 32'h0001_2345, 32'hFFFF_FFFE, 10, cyc, bc);
    chk("mult_inj_cycle", 64'(cyc), 64'd34);
    chk("mult_inj_hilo",  {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFD_B976);
    @(posedge clk); #1;
    chk("mult_inj_idle", {62'd0, bus32.busy, bus32.done}, 64'd0);

    // Reset asserted during cycle 15 of a multiply.
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.op = 3'd0; bus32.a = 32'd3; bus32.b = 32'd5;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    chk("rstmid_busy_before", {63'd0, bus32.busy}, 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rstmid_hilo", {bus32.hi, bus32.lo}, 64'd0);
    chk("rstmid_busy_done", {62'd0, bus32.busy, bus32.done}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.done || bus32.busy) done_seen++;
    end
    chk("rstmid_no_done", 64'(done_seen), 64'd0);
    $display("reset mid-mult -> hi=%h lo=%h activity_after=%0d", bus32.hi, bus32.lo, done_seen);

    // WIDTH=8 regression.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.op = 3'd0; bus8.a = 8'h81; bus8.b = 8'h02;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    cyc = 1;
    while (!bus8.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    $display("w8 mult a=81 b=02 -> hi=%h lo=%h done_cycle=%0d", bus8.hi, bus8.lo, cyc);
    chk("w8_done_seen", {63'd0, bus8.done}, 64'd1);
    chk("w8_cycle", 64'(cyc), 64'd10);
    chk("w8_hilo", {48'd0, bus8.hi, bus8.lo}, 64'h0000_0000_0000_FF02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
